// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter and load sequencer for a shared enable-load register.
// Optional release timeout: define REG_LOAD_ARB_TIMEOUT_EN.
module reg_load_arbiter #(
  parameter int GID_W    = 2,
  parameter int WIDTH    = 4,
  parameter int HOLD_MAX = 15,
  localparam int N_REQ   = 2**GID_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] din_bus,
  output logic                   En,
  output logic [WIDTH-1:0]       Din,
  output logic [N_REQ-1:0]       ack,
  output logic [GID_W-1:0]       grant_id,
  output logic                   busy,
  output logic                   err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  if (HOLD_MAX < 1) begin : g_chk
    $error("HOLD_MAX must be at least 1");
  end

  logic [1:0]       state;
  logic [GID_W-1:0] rr_ptr;
  logic [GID_W-1:0] pick;
  logic             pick_valid;
  logic [WIDTH-1:0] pick_data;

`ifdef REG_LOAD_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
  logic [CNT_W-1:0] cnt;
`endif

  // First set request at or after rr_ptr, wrapping around.
  always_comb begin
    logic [GID_W-1:0] idx;
    pick       = rr_ptr;
    pick_valid = 1'b0;
    idx        = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = rr_ptr + GID_W'(k);
      if (req[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
    pick_data = din_bus[pick*WIDTH +: WIDTH];
  end

  // Grant / load / ack / release sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      En       <= 1'b0;
      Din      <= '0;
      ack      <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      rr_ptr   <= '0;
`ifdef REG_LOAD_ARB_TIMEOUT_EN
      err      <= 1'b0;
      cnt      <= '0;
`endif
    end else begin
      En  <= 1'b0;
      ack <= '0;
`ifdef REG_LOAD_ARB_TIMEOUT_EN
      err <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (pick_valid) begin
            state    <= S_LOAD;
            En       <= 1'b1;
            Din      <= pick_data;
            grant_id <= pick;
            rr_ptr   <= pick + GID_W'(1);
            busy     <= 1'b1;
          end
        end
        S_LOAD: begin
          state         <= S_ACK;
          ack[grant_id] <= 1'b1;
        end
        S_ACK: begin
          state <= S_WAIT;
`ifdef REG_LOAD_ARB_TIMEOUT_EN
          cnt   <= '0;
`endif
        end
        S_WAIT: begin
          if (!req[grant_id]) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
`ifdef REG_LOAD_ARB_TIMEOUT_EN
          else if (cnt == CNT_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifndef REG_LOAD_ARB_TIMEOUT_EN
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_load_arbiter.sv
// Scoreboard bench for reg_load_arbiter.
// Expected loads are queued by stimulus and checked by a monitor.
module tb_reg_load_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] din_bus;
  logic        En;
  logic [3:0]  Din;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err;

  logic [3:0]  ext_reg;

  typedef struct {
    logic [1:0] gid;
    logic [3:0] din;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  reg_load_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .din_bus  (din_bus),
    .En       (En),
    .Din      (Din),
    .ack      (ack),
    .grant_id (grant_id),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // External enable-load register model.
  always @(posedge clk) begin
    if (En) ext_reg <= Din;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_din(input int i, input logic [3:0] v);
    din_bus[i*4 +: 4] = v;
  endtask

  task automatic push(input logic [1:0] g, input logic [3:0] d);
    exp_t e;
    e.gid = g;
    e.din = d;
    q.push_back(e);
  endtask

  task automatic wait_ack(input int g);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (ack[g] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_ack%0d: got timeout expected ack", g);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Monitor: each load pops the queue; the cycle after must be the ack.
  initial begin
    exp_t       e;
    logic       pend;
    logic [3:0] pend_ack;
    logic [3:0] want;
    pend     = 1'b0;
    pend_ack = '0;
    forever begin
      @(negedge clk);
      if (pend) begin
        want = rst ? 4'b0 : pend_ack;
        checks++;
        if (ack !== want || En !== 1'b0) begin
          errors++;
          $display("FAIL ack_phase: got ack=%b En=%b expected ack=%b En=0",
                   ack, En, want);
        end
        pend = 1'b0;
      end else if (ack !== 4'b0) begin
        checks++;
        errors++;
        $display("FAIL stray_ack: got %b expected 0000", ack);
      end
      if (En === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stray_load: got Din=%h gid=%0d expected none",
                   Din, grant_id);
        end else begin
          e = q.pop_front();
          if (Din !== e.din || grant_id !== e.gid) begin
            errors++;
            $display("FAIL load: got Din=%h gid=%0d expected Din=%h gid=%0d",
                     Din, grant_id, e.din, e.gid);
          end
          pend     = 1'b1;
          pend_ack = 4'b0001 << e.gid;
        end
      end
    end
  end

  initial begin
    req     = '0;
    din_bus = '0;
    rst     = 1'b1;
    tick();
    do_reset();

    chk("rst_En", 32'(En), 32'd0);
    chk("rst_Din", 32'(Din), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Single request
    set_din(0, 4'hA);
    push(2'd0, 4'hA);
    req = 4'b0001;
    wait_ack(0);
    req = 4'b0000;
    tick();
    chk("t1_busy_wait", 32'(busy), 32'd1);
    tick();
    chk("t1_busy_idle", 32'(busy), 32'd0);
    chk("t1_din_hold", 32'(Din), 32'hA);
    chk("t1_ext_reg", 32'(ext_reg), 32'hA);

    // Round-robin fairness
    do_reset();
    set_din(0, 4'h1);
    set_din(1, 4'h2);
    set_din(2, 4'h3);
    set_din(3, 4'h4);
    push(2'd0, 4'h1);
    push(2'd1, 4'h2);
    push(2'd2, 4'h3);
    push(2'd3, 4'h4);
    push(2'd0, 4'h1);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(k);
      req[k] = 1'b0;
      tick();
      tick();
      req[k] = 1'b1;
    end
    wait_ack(0);
    req = 4'b0000;
    tick();
    tick();
    chk("t2_gid_last", 32'(grant_id), 32'd0);

    // Data stability during LOAD
    set_din(2, 4'h5);
    push(2'd2, 4'h5);
    req = 4'b0100;
    tick();
    chk("t3_in_load_En", 32'(En), 32'd1);
    set_din(2, 4'hF);
    chk("t3_in_load_Din", 32'(Din), 32'h5);
    tick();
    chk("t3_ext_reg", 32'(ext_reg), 32'h5);
    wait_ack(2);
    req = 4'b0000;
    tick();
    tick();
    chk("t3_din_hold", 32'(Din), 32'h5);

    // Hold in WAIT_REL
    set_din(1, 4'h7);
    set_din(3, 4'h9);
    push(2'd1, 4'h7);
    req = 4'b0010;
    wait_ack(1);
    for (int n = 0; n < 10; n++) begin
      if (n == 2) req[3] = 1'b1;
      tick();
    end
    chk("t4_hold_busy", 32'(busy), 32'd1);
    chk("t4_hold_gid", 32'(grant_id), 32'd1);
    push(2'd3, 4'h9);
    req[1] = 1'b0;
    wait_ack(3);
    req = 4'b0000;
    tick();
    tick();

    // Reset during LOAD
    set_din(0, 4'hC);
    set_din(1, 4'hD);
    push(2'd0, 4'hC);
    req = 4'b0001;
    tick();
    chk("t5_load_En", 32'(En), 32'd1);
    rst = 1'b1;
    tick();
    chk("t5_En", 32'(En), 32'd0);
    chk("t5_ack", 32'(ack), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_gid", 32'(grant_id), 32'd0);
    chk("t5_Din", 32'(Din), 32'd0);
    chk("t5_ext_reg", 32'(ext_reg), 32'hC);
    tick();
    rst = 1'b0;
    push(2'd0, 4'hC);
    req = 4'b0011;
    wait_ack(0);
    req = 4'b0000;
    tick();
    tick();

    // Requester never releases
    set_din(0, 4'h3);
    push(2'd0, 4'h3);
    req = 4'b0001;
    wait_ack(0);
    tick();
`ifdef REG_LOAD_ARB_TIMEOUT_EN
    push(2'd0, 4'h3);
    for (int n = 0; n < 14; n++) begin
      tick();
      chk("t6_err_early", 32'(err), 32'd0);
    end
    tick();
    chk("t6_err_pulse", 32'(err), 32'd1);
    chk("t6_busy_idle", 32'(busy), 32'd0);
    tick();
    chk("t6_err_drop", 32'(err), 32'd0);
    chk("t6_regrant", 32'(En), 32'd1);
    wait_ack(0);
`else
    for (int n = 0; n < 20; n++) begin
      tick();
      chk("t6_no_err", 32'(err), 32'd0);
    end
    chk("t6_still_busy", 32'(busy), 32'd1);
`endif
    req = 4'b0000;
    tick();
    tick();
    tick();
    chk("queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
